data_mem_arbiter: RTL

- Shares one single-port on-chip data RAM between two Avalon-MM masters (m0, m1).
- RAM geometry: 8192 x 32, byte enables, address registered inside the RAM, q unregistered, so read data appears 1 clock after issue.
- Block performs round-robin arbitration with a bounded grant-hold, drives the RAM port, and returns read data with readdatavalid to the correct master.
- Sits between the interconnect masters and the RAM instance, replacing direct multi-master wiring.

---
 rtl/data_mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port 8192x32 data RAM between two
// Avalon-MM masters (m0, m1). Round-robin with a bounded grant-hold, the
// access issues in the grant cycle, and read data returns one clock later
// with readdatavalid steered to the master that issued the read.
// Optional build macro: DATA_MEM_ARB_STATS_EN adds 32-bit grant/conflict
// counters (stat_grant0, stat_grant1, stat_conflict).
module data_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  // master 0
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic                m0_waitrequest,
  // master 1
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                m1_waitrequest,
  // RAM port
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
`ifdef DATA_MEM_ARB_STATS_EN
  output logic [31:0]         stat_grant0,
  output logic [31:0]         stat_grant1,
  output logic [31:0]         stat_conflict,
`endif
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic              req0, req1;
  logic              pick1;       // winner if anyone is granted: 0 = m0, 1 = m1
  logic              any_grant;
  logic              grant0, grant1;
  logic              issue_read;

  logic              last_owner;
  logic [3:0]        hold_cnt;
  logic              rd_pend;
  logic              rd_owner;
  logic [DATA_W-1:0] rd_hold0, rd_hold1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Pick the winner: lone requester wins; under contention the last owner
  // keeps the port until it has used up its hold budget.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pick1 = req1;
    if (req0 && req1) begin
      pick1 = (hold_cnt < HOLD_MAX) ? last_owner : ~last_owner;
    end
  end

  // Nothing is granted while reset is asserted.
  assign any_grant  = ~reset & (req0 | req1);
  assign grant1     = any_grant & pick1;
  assign grant0     = any_grant & ~pick1;
  // A write on the winning master takes precedence over a read.
  assign issue_read = any_grant & ~(pick1 ? m1_write : m0_write);

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);
  assign mem_clken      = ~reset;

  // Drive the RAM port from the granted master; all zeros when idle.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (grant0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end else if (grant1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
  end

  // Track the owner of the last grant and how long it has held the port.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      last_owner <= 1'b0;
      hold_cnt   <= '0;
    end else if (any_grant) begin
      last_owner <= pick1;
      if (pick1 != last_owner) begin
        hold_cnt <= 4'd1;
      end else if (hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end else begin
      // Both masters idle: the streak is over.
      hold_cnt <= '0;
    end
  end

  // Remember which master owns the read data arriving on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= issue_read;
      if (issue_read) begin
        rd_owner <= pick1;
      end
    end
  end

  // Keep each master's last returned word so its readdata stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hold0 <= '0;
      rd_hold1 <= '0;
    end else if (rd_pend) begin
      if (rd_owner) rd_hold1 <= mem_readdata;
      else          rd_hold0 <= mem_readdata;
    end
  end

  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend &  rd_owner;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : rd_hold0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : rd_hold1;

`ifdef DATA_MEM_ARB_STATS_EN
  // Free-running grant and contention counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0)        stat_grant0   <= stat_grant0 + 32'd1;
      if (grant1)        stat_grant1   <= stat_grant1 + 32'd1;
      if (req0 && req1)  stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule
